// File: rtl/bus_sram_responder_pkg.sv
// Shared bus definitions for bus slaves: transfer type and size encodings,
// plus the byte-lane helpers every SRAM-style responder needs.
package bus_sram_responder_pkg;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } ttype_e;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } tsize_e;

    // The one size encoding with no transfer behind it.
    localparam logic [1:0] TSIZE_ILLEGAL = 2'b11;

    // Byte-enable mask for a transfer of the given size starting at byte lane 'lane'.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] mask;
        case (size)
            BYTE:    mask = 4'b0001 << lane;
            HALF:    mask = 4'b0011 << lane;
            WORD:    mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

    // Move right-justified write data up to its byte lane.
    function automatic logic [31:0] wr_shift(input logic [31:0] data, input logic [1:0] lane);
        return data << {lane, 3'b000};
    endfunction

    // Bring the addressed lanes down to bit 0 and zero everything above the transfer size.
    function automatic logic [31:0] rd_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane);
        logic [31:0] shifted;
        logic [31:0] data;
        shifted = word >> {lane, 3'b000};
        case (size)
            BYTE:    data = shifted & 32'h0000_00FF;
            HALF:    data = shifted & 32'h0000_FFFF;
            WORD:    data = shifted;
            default: data = 32'h0000_0000;
        endcase
        return data;
    endfunction

    // Force a lane onto the natural boundary of the transfer size.
    function automatic logic [1:0] align_lane(input logic [1:0] size, input logic [1:0] lane);
        logic [1:0] aligned;
        case (size)
            HALF:    aligned = {lane[1], 1'b0};
            WORD:    aligned = 2'b00;
            default: aligned = lane;
        endcase
        return aligned;
    endfunction

endpackage

// File: rtl/sp_ram_be.sv
// Single-port 32-bit SRAM with four byte-write enables and a synchronous,
// registered read port. Read returns the word as it was before any same-edge write.
module sp_ram_be #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Byte-masked write and registered read on every enabled edge.
    // NOTE: no reset here on purpose -- a memory array cannot be cleared in one cycle, and a
    // reset term would stop synthesis from mapping this onto an SRAM macro.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < 4; b++) begin
                if (we[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/bus_sram_responder.sv
// Bus slave that decodes one address window onto a word-wide SRAM, inserts
// WAIT_CYCLES wait states and answers with a one-cycle bdone/berror pulse.
// Build option: define MISALIGN_ERR_EN to report misaligned HALF/WORD accesses
// as errors; otherwise the low address bits are forced aligned.
module bus_sram_responder
    import bus_sram_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        breq,
    output logic        bgnt,
    input  logic        bstart,
    input  logic        ttype,
    input  logic [1:0]  tsize,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        bdone,
    output logic        berror
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    localparam int          AW           = $clog2(DEPTH_WORDS);
    localparam logic [31:0] WINDOW_BYTES = 32'(4 * DEPTH_WORDS);
    localparam bit          NO_WAIT      = (WAIT_CYCLES == 0);
    localparam logic [3:0]  WAIT_INIT    = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_e      state;
    logic [3:0]  cnt;

    // Request captured at acceptance, used while the bus inputs may have moved on.
    logic        q_ttype;
    logic [1:0]  q_tsize;
    logic [31:0] q_addr;
    logic [31:0] q_wdata;

    // Context needed to format read data during the response cycle.
    logic [1:0]  resp_lane;
    logic [1:0]  resp_size;
    logic        rd_ok;

    logic        accept;
    logic        enter_resp;
    logic        cur_ttype;
    logic [1:0]  cur_tsize;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [31:0] offset;
    logic        in_range;
    logic        size_bad;
    logic        misalign;
    logic        acc_err;
    logic [1:0]  lane;

    logic          ram_en;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    assign accept     = (state == ST_IDLE) && breq && bgnt && bstart;
    // The SRAM is touched on the edge that moves the FSM into RESP.
    assign enter_resp = (accept && NO_WAIT) || ((state == ST_WAIT) && (cnt == 4'd0));

    // Pick the access source: live bus in IDLE (zero-wait case), latched copy afterwards.
    // NOTE: every output gets a default first so no path through the block leaves one
    // unassigned; an unassigned path would infer a latch.
    always_comb begin
        cur_ttype = q_ttype;
        cur_tsize = q_tsize;
        cur_addr  = q_addr;
        cur_wdata = q_wdata;
        if (state == ST_IDLE) begin
            cur_ttype = ttype;
            cur_tsize = tsize;
            cur_addr  = addr;
            cur_wdata = wdata;
        end
    end

    // BASE_ADDR is word aligned, so offset[1:0] equals the address lane.
    assign offset   = cur_addr - BASE_ADDR;
    assign in_range = (cur_addr >= BASE_ADDR) && (offset < WINDOW_BYTES);
    assign size_bad = (cur_tsize == TSIZE_ILLEGAL);

`ifdef MISALIGN_ERR_EN
    assign misalign = ((cur_tsize == HALF) && offset[0]) ||
                      ((cur_tsize == WORD) && (offset[1:0] != 2'b00));
    assign lane     = offset[1:0];
`else
    assign misalign = 1'b0;
    assign lane     = align_lane(cur_tsize, offset[1:0]);
`endif

    assign acc_err   = !in_range || size_bad || misalign;
    assign ram_en    = enter_resp && !acc_err;
    assign ram_we    = (ram_en && (cur_ttype == WRITE)) ? lane_mask(cur_tsize, lane) : 4'b0000;
    assign ram_addr  = offset[AW+1:2];
    assign ram_wdata = wr_shift(cur_wdata, lane);

    sp_ram_be #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Grant mirror, request capture, wait counting and the registered response pulse.
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples
    // values from before the edge regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            bgnt      <= 1'b0;
            bdone     <= 1'b0;
            berror    <= 1'b0;
            rd_ok     <= 1'b0;
            resp_lane <= 2'b00;
            resp_size <= 2'b00;
            q_ttype   <= 1'b0;
            q_tsize   <= 2'b00;
            q_addr    <= 32'h0000_0000;
            q_wdata   <= 32'h0000_0000;
        end else begin
            bgnt   <= breq;
            bdone  <= 1'b0;
            berror <= 1'b0;
            rd_ok  <= 1'b0;

            if (enter_resp) begin
                bdone     <= 1'b1;
                berror    <= acc_err;
                rd_ok     <= !acc_err && (cur_ttype == READ);
                resp_lane <= lane;
                resp_size <= cur_tsize;
            end

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        q_ttype <= ttype;
                        q_tsize <= tsize;
                        q_addr  <= addr;
                        q_wdata <= wdata;
                        if (NO_WAIT) begin
                            state <= ST_RESP;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= WAIT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= ST_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Read data is presented only alongside a successful read's bdone, zero otherwise.
    assign rdata = rd_ok ? rd_extract(ram_rdata, resp_size, resp_lane) : 32'h0000_0000;

endmodule

// File: tb/tb_bus_sram_responder.sv
// Directed bench for bus_sram_responder: a zero-wait instance (window 0x00..0x3F)
// and a three-wait instance (window 0x100..0x13F). Honours MISALIGN_ERR_EN if defined.
module tb_bus_sram_responder;
    import bus_sram_responder_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    logic        breq0, bstart0, ttype0, bgnt0, bdone0, berror0;
    logic [1:0]  tsize0;
    logic [31:0] addr0, wdata0, rdata0;

    logic        breq3, bstart3, ttype3, bgnt3, bdone3, berror3;
    logic [1:0]  tsize3;
    logic [31:0] addr3, wdata3, rdata3;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    logic [31:0] r_rd;
    logic        r_err;
    logic        r_after;
    int          r_lat;
    logic [8:0]  pulses;
    logic [31:0] t_rd;
    logic        any_done;

    bus_sram_responder #(.BASE_ADDR(32'h0000_0000), .DEPTH_WORDS(16), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .breq(breq0), .bgnt(bgnt0), .bstart(bstart0),
        .ttype(ttype0), .tsize(tsize0), .addr(addr0), .wdata(wdata0),
        .rdata(rdata0), .bdone(bdone0), .berror(berror0)
    );

    bus_sram_responder #(.BASE_ADDR(32'h0000_0100), .DEPTH_WORDS(16), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .breq(breq3), .bgnt(bgnt3), .bstart(bstart3),
        .ttype(ttype3), .tsize(tsize3), .addr(addr3), .wdata(wdata3),
        .rdata(rdata3), .bdone(bdone3), .berror(berror3)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, required finish before 100000");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete transfer on instance sel (0 = zero-wait, 1 = three-wait). The request is
    // dropped and the inputs scrambled right after acceptance. lat = cycles from accept edge
    // to the edge that samples bdone high (0 if it never came).
    task automatic xfer(input bit sel, input logic tt, input logic [1:0] ts,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic err, output int lat,
                        output logic done_after);
        bit seen;
        @(negedge clk);
        if (!sel) begin
            bstart0 = 1'b1; ttype0 = tt; tsize0 = ts; addr0 = a; wdata0 = wd;
        end else begin
            bstart3 = 1'b1; ttype3 = tt; tsize3 = ts; addr3 = a; wdata3 = wd;
        end
        @(posedge clk);
        @(negedge clk);
        if (!sel) begin
            breq0 = 1'b0; bstart0 = 1'b0; addr0 = 32'hFFFF_FFFF; wdata0 = 32'h0;
        end else begin
            breq3 = 1'b0; bstart3 = 1'b0; addr3 = 32'hFFFF_FFFF; wdata3 = 32'h0;
        end
        seen = 1'b0;
        lat  = 0;
        rd   = 32'h0;
        err  = 1'b0;
        for (int i = 1; i <= 12 && !seen; i++) begin
            if (sel ? bdone3 : bdone0) begin
                seen = 1'b1;
                lat  = i;
                rd   = sel ? rdata3 : rdata0;
                err  = sel ? berror3 : berror0;
            end else begin
                @(negedge clk);
            end
        end
        @(negedge clk);
        done_after = sel ? bdone3 : bdone0;
        if (!sel) breq0 = 1'b1;
        else      breq3 = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        breq0 = 0; bstart0 = 0; ttype0 = 0; tsize0 = 0; addr0 = 0; wdata0 = 0;
        breq3 = 0; bstart3 = 0; ttype3 = 0; tsize3 = 0; addr3 = 0; wdata3 = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_bgnt", 32'(bgnt0), 32'h0);
        check("rst_bdone", 32'(bdone0), 32'h0);
        check("rst_berror", 32'(berror0), 32'h0);
        check("rst_rdata", rdata0, 32'h0);
        rst_n = 1'b1;
        breq0 = 1'b1;
        breq3 = 1'b1;
        @(negedge clk);
        check("bgnt_follows_breq", 32'(bgnt0), 32'h1);
        check("idle_no_bdone", 32'(bdone0), 32'h0);

        // Zero-wait word write/read
        xfer(0, WRITE, WORD, 32'h10, 32'hDEAD_BEEF, r_rd, r_err, r_lat, r_after);
        check("w0_word_err", 32'(r_err), 32'h0);
        check("w0_word_lat", 32'(r_lat), 32'd1);
        check("w0_pulse_width", 32'(r_after), 32'h0);
        xfer(0, READ, WORD, 32'h10, 32'h0, r_rd, r_err, r_lat, r_after);
        check("r0_word_data", r_rd, 32'hDEAD_BEEF);
        check("r0_word_err", 32'(r_err), 32'h0);
        check("r0_word_lat", 32'(r_lat), 32'd1);

        // Byte merge into an existing word and narrow reads
        xfer(0, WRITE, WORD, 32'h10, 32'h1122_3344, r_rd, r_err, r_lat, r_after);
        xfer(0, WRITE, BYTE, 32'h13, 32'h0000_00AA, r_rd, r_err, r_lat, r_after);
        check("w0_byte_err", 32'(r_err), 32'h0);
        xfer(0, READ, WORD, 32'h10, 32'h0, r_rd, r_err, r_lat, r_after);
        check("r0_after_byte", r_rd, 32'hAA22_3344);
        xfer(0, READ, BYTE, 32'h13, 32'h0, r_rd, r_err, r_lat, r_after);
        check("r0_byte_lane3", r_rd, 32'h0000_00AA);
        xfer(0, READ, HALF, 32'h12, 32'h0, r_rd, r_err, r_lat, r_after);
        check("r0_half_lane2", r_rd, 32'h0000_AA22);

        // Out of range: first address past the window must not alias onto word 0
        xfer(0, WRITE, WORD, 32'h00, 32'h5566_7788, r_rd, r_err, r_lat, r_after);
        xfer(0, WRITE, WORD, 32'h40, 32'h1234_5678, r_rd, r_err, r_lat, r_after);
        check("w0_oor_err", 32'(r_err), 32'h1);
        check("w0_oor_lat", 32'(r_lat), 32'd1);
        xfer(0, READ, WORD, 32'h40, 32'h0, r_rd, r_err, r_lat, r_after);
        check("r0_oor_err", 32'(r_err), 32'h1);
        check("r0_oor_data", r_rd, 32'h0);
        xfer(0, READ, WORD, 32'h00, 32'h0, r_rd, r_err, r_lat, r_after);
        check("r0_word0_kept", r_rd, 32'h5566_7788);

        // Last word of the window is legal
        xfer(0, WRITE, WORD, 32'h3C, 32'hCAFE_F00D, r_rd, r_err, r_lat, r_after);
        check("w0_last_err", 32'(r_err), 32'h0);
        xfer(0, READ, WORD, 32'h3C, 32'h0, r_rd, r_err, r_lat, r_after);
        check("r0_last_data", r_rd, 32'hCAFE_F00D);

        // Illegal size
        xfer(0, READ, 2'b11, 32'h10, 32'h0, r_rd, r_err, r_lat, r_after);
        check("r0_size3_err", 32'(r_err), 32'h1);
        check("r0_size3_data", r_rd, 32'h0);
        xfer(0, WRITE, 2'b11, 32'h10, 32'hFFFF_FFFF, r_rd, r_err, r_lat, r_after);
        check("w0_size3_err", 32'(r_err), 32'h1);
        xfer(0, READ, WORD, 32'h10, 32'h0, r_rd, r_err, r_lat, r_after);
        check("r0_size3_kept", r_rd, 32'hAA22_3344);

        // Alignment: HALF @0x22 is naturally aligned; HALF @0x21 and WORD @0x11 are not
        xfer(0, WRITE, WORD, 32'h20, 32'h9988_7766, r_rd, r_err, r_lat, r_after);
        xfer(0, WRITE, HALF, 32'h22, 32'h0000_BEEF, r_rd, r_err, r_lat, r_after);
        check("w0_half22_err", 32'(r_err), 32'h0);
        xfer(0, READ, WORD, 32'h20, 32'h0, r_rd, r_err, r_lat, r_after);
        check("r0_half22_word", r_rd, 32'hBEEF_7766);
        xfer(0, WRITE, HALF, 32'h21, 32'h0000_1234, r_rd, r_err, r_lat, r_after);
`ifdef MISALIGN_ERR_EN
        check("w0_half21_err", 32'(r_err), 32'h1);
        xfer(0, READ, WORD, 32'h20, 32'h0, r_rd, r_err, r_lat, r_after);
        check("r0_half21_word", r_rd, 32'hBEEF_7766);
        xfer(0, READ, WORD, 32'h11, 32'h0, r_rd, r_err, r_lat, r_after);
        check("r0_word11_err", 32'(r_err), 32'h1);
        check("r0_word11_data", r_rd, 32'h0);
`else
        check("w0_half21_err", 32'(r_err), 32'h0);
        xfer(0, READ, WORD, 32'h20, 32'h0, r_rd, r_err, r_lat, r_after);
        check("r0_half21_word", r_rd, 32'hBEEF_1234);
        xfer(0, READ, WORD, 32'h11, 32'h0, r_rd, r_err, r_lat, r_after);
        check("r0_word11_err", 32'(r_err), 32'h0);
        check("r0_word11_data", r_rd, 32'hAA22_3344);
`endif

        // Three-wait instance: latency, latched request, window lower bound
        xfer(1, WRITE, WORD, 32'h104, 32'h0BAD_F00D, r_rd, r_err, r_lat, r_after);
        check("w3_err", 32'(r_err), 32'h0);
        check("w3_lat", 32'(r_lat), 32'd4);
        check("w3_pulse_width", 32'(r_after), 32'h0);
        xfer(1, READ, WORD, 32'h104, 32'h0, r_rd, r_err, r_lat, r_after);
        check("r3_data", r_rd, 32'h0BAD_F00D);
        check("r3_lat", 32'(r_lat), 32'd4);
        xfer(1, READ, WORD, 32'hFC, 32'h0, r_rd, r_err, r_lat, r_after);
        check("r3_below_base_err", 32'(r_err), 32'h1);

        // Back-to-back with bstart held: bdone after edges N+3 and N+8 (accepts at N, N+5)
        @(negedge clk);
        bstart3 = 1'b1; ttype3 = READ; tsize3 = WORD; addr3 = 32'h104;
        @(posedge clk);
        t_rd = 32'h0;
        for (int j = 0; j < 9; j++) begin
            @(negedge clk);
            pulses[j] = bdone3;
            if (j == 3) t_rd = rdata3;
        end
        bstart3 = 1'b0;
        check("r3_b2b_pulses", 32'(pulses), 32'h108);
        check("r3_b2b_data", t_rd, 32'h0BAD_F00D);
        @(negedge clk);

        // Reset during WAIT of a write: dropped, no bdone, old word kept
        xfer(1, WRITE, WORD, 32'h108, 32'h1111_1111, r_rd, r_err, r_lat, r_after);
        @(negedge clk);
        bstart3 = 1'b1; ttype3 = WRITE; tsize3 = WORD; addr3 = 32'h108; wdata3 = 32'h2222_2222;
        @(posedge clk);
        @(negedge clk);
        bstart3 = 1'b0;
        breq3   = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_wait_bdone", 32'(bdone3), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_release_bgnt", 32'(bgnt3), 32'h0);
        breq3 = 1'b1;
        any_done = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            any_done = any_done | bdone3;
        end
        check("rst_wait_no_bdone", 32'(any_done), 32'h0);
        xfer(1, READ, WORD, 32'h108, 32'h0, r_rd, r_err, r_lat, r_after);
        check("rst_wait_word_kept", r_rd, 32'h1111_1111);
        xfer(0, READ, WORD, 32'h3C, 32'h0, r_rd, r_err, r_lat, r_after);
        check("r0_post_reset", r_rd, 32'hCAFE_F00D);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
